if_mem_resp: RTL

- Memory-side responder for the instruction-fetch handshake. The fetch stage raises a request with a PC and waits; this block returns the 32-bit word with a one-cycle ok pulse.
- Also serves load/store requests from the MEM stage.
- All traffic goes over the single byte-wide synchronous RAM port. Transactions are sequenced byte by byte through a small FSM.
- Sits between the IF/MEM stages and the RAM.

---
 rtl/if_mem_resp_if.sv | 40 ++++
 rtl/if_mem_resp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_mem_resp_if.sv
// Bundles the fetch, load/store and byte-wide RAM signals of the memory responder.
// Requests are level-held: req stays high until the matching one-cycle ok pulse is seen.
interface if_mem_resp_if #(
    parameter int ADDR_W = 17
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic              if_ok;
    logic [31:0]       if_data;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              mem_ok;
    logic [31:0]       mem_rdata;

    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              ram_wr;

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        output ram_din,
        input  if_ok, if_data, mem_ok, mem_rdata,
        input  ram_a, ram_dout, ram_wr
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        input  ram_din,
        output if_ok, if_data, mem_ok, mem_rdata,
        output ram_a, ram_dout, ram_wr
    );
endinterface

// File: rtl/if_mem_resp.sv
// Memory-side responder: serialises fetch and load/store requests onto a byte-wide
// synchronous RAM (1-cycle read latency) and returns results with a one-cycle ok pulse.
module if_mem_resp #(
    parameter int ADDR_W = 17
) (
    input  logic         clk,
    input  logic         rst,
    if_mem_resp_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [31:0]       addr_q;
    logic [23:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_rdata_q;
    logic              if_ok_q;
    logic              mem_ok_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_dout_q;
    logic              ram_wr_q;

    logic [2:0]        mem_n_d;
    logic [31:0]       next_a_d;
    logic [31:0]       merged_d;
    logic [7:0]        wbyte_d;

    always_comb begin
        case (bus.mem_len)
            2'd0:    mem_n_d = 3'd1;
            2'd1:    mem_n_d = 3'd2;
            default: mem_n_d = 3'd4;
        endcase
    end

    assign next_a_d = addr_q + {29'd0, cnt_q} + 32'd1;

    // cnt_q counts cycles in the read state; byte cnt_q-1 arrives on ram_din now.
    always_comb begin
        merged_d = buf_q;
        case (cnt_q)
            3'd1:    merged_d[7:0]   = bus.ram_din;
            3'd2:    merged_d[15:8]  = bus.ram_din;
            3'd3:    merged_d[23:16] = bus.ram_din;
            3'd4:    merged_d[31:24] = bus.ram_din;
            default: ;
        endcase
    end

    // Byte 0 goes out straight from the request; wdata_q keeps bytes 1..3.
    always_comb begin
        case (cnt_q)
            3'd0:    wbyte_d = wdata_q[7:0];
            3'd1:    wbyte_d = wdata_q[15:8];
            3'd2:    wbyte_d = wdata_q[23:16];
            default: wbyte_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 24'd0;
            buf_q       <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ok_q     <= 1'b0;
            mem_ok_q    <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
        end else begin
            if_ok_q  <= 1'b0;
            mem_ok_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q      <= 3'd0;
                    ram_a_q    <= '0;
                    ram_dout_q <= 8'd0;
                    ram_wr_q   <= 1'b0;
                    // The requester still holds req during its ok cycle, so skip it.
                    if (!if_ok_q && !mem_ok_q) begin
                        if (bus.mem_req) begin
                            addr_q  <= bus.mem_addr;
                            wdata_q <= bus.mem_wdata[31:8];
                            n_q     <= mem_n_d;
                            buf_q   <= 32'd0;
                            ram_a_q <= bus.mem_addr[ADDR_W-1:0];
                            if (bus.mem_we) begin
                                state_q    <= MEM_WR;
                                ram_wr_q   <= 1'b1;
                                ram_dout_q <= bus.mem_wdata[7:0];
                            end else begin
                                state_q <= MEM_RD;
                            end
                        end else if (bus.if_req && !bus.if_flush) begin
                            addr_q  <= bus.if_addr;
                            n_q     <= 3'd4;
                            buf_q   <= 32'd0;
                            ram_a_q <= bus.if_addr[ADDR_W-1:0];
                            state_q <= IF_RD;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state_q == IF_RD && bus.if_flush) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                        ram_a_q <= '0;
                    end else begin
                        buf_q   <= merged_d;
                        cnt_q   <= cnt_q + 3'd1;
                        ram_a_q <= (cnt_q + 3'd1 < n_q) ? next_a_d[ADDR_W-1:0] : '0;
                        if (cnt_q == n_q) begin
                            state_q <= IDLE;
                            cnt_q   <= 3'd0;
                            if (state_q == IF_RD) begin
                                if_ok_q   <= 1'b1;
                                if_data_q <= merged_d;
                            end else begin
                                mem_ok_q    <= 1'b1;
                                mem_rdata_q <= merged_d;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt_q + 3'd1 < n_q) begin
                        cnt_q      <= cnt_q + 3'd1;
                        ram_a_q    <= next_a_d[ADDR_W-1:0];
                        ram_dout_q <= wbyte_d;
                    end else begin
                        state_q    <= IDLE;
                        cnt_q      <= 3'd0;
                        ram_a_q    <= '0;
                        ram_dout_q <= 8'd0;
                        ram_wr_q   <= 1'b0;
                        mem_ok_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_ok     = if_ok_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_ok    = mem_ok_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    // Reset must also stop the byte that is on the bus during the reset cycle.
    assign bus.ram_wr    = ram_wr_q & ~rst;
    assign dbg_state_o   = state_q;
endmodule
